// File: rtl/seg_pkg.sv
// Shared glyphs, limits, conversion state and double-dabble helper
// for the classic-mode seven-segment score display.
package seg_pkg;

  localparam logic [15:0] SEG_MAX_VALUE = 16'd9999;

  // Active-low a..g, bit 0 = segment a
  localparam logic [6:0] GLYPH_0     = 7'h40;
  localparam logic [6:0] GLYPH_1     = 7'h79;
  localparam logic [6:0] GLYPH_2     = 7'h24;
  localparam logic [6:0] GLYPH_3     = 7'h30;
  localparam logic [6:0] GLYPH_4     = 7'h19;
  localparam logic [6:0] GLYPH_5     = 7'h12;
  localparam logic [6:0] GLYPH_6     = 7'h02;
  localparam logic [6:0] GLYPH_7     = 7'h78;
  localparam logic [6:0] GLYPH_8     = 7'h00;
  localparam logic [6:0] GLYPH_9     = 7'h10;
  localparam logic [6:0] GLYPH_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } conv_state_t;

  function automatic logic [6:0] glyph(
    input logic [3:0] d
  );
    logic [6:0] g;
    case (d)
      4'd0:    g = GLYPH_0;
      4'd1:    g = GLYPH_1;
      4'd2:    g = GLYPH_2;
      4'd3:    g = GLYPH_3;
      4'd4:    g = GLYPH_4;
      4'd5:    g = GLYPH_5;
      4'd6:    g = GLYPH_6;
      4'd7:    g = GLYPH_7;
      4'd8:    g = GLYPH_8;
      4'd9:    g = GLYPH_9;
      default: g = GLYPH_BLANK;
    endcase
    return g;
  endfunction

  // Add 3 to every BCD nibble that is 5 or more
  function automatic logic [15:0] dabble_adj(
    input logic [15:0] b
  );
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (b[i*4 +: 4] >= 4'd5) begin
        r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_display_classic_bin2bcd.sv
// Sequential 16-bit binary to 4-digit BCD converter (double dabble).
// Ports: clk, rst, start, din -> busy, load, done, bcd.
module bin2bcd_seq
  import seg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] din,
  output logic        busy,
  output logic        load,
  output logic        done,
  output logic [15:0] bcd
);

  conv_state_t state_q, state_d;
  logic [15:0] sr_q, sr_d;
  logic [15:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] adj;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    adj     = dabble_adj(acc_q);
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        sr_d    = din;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        {acc_d, sr_d} = {adj[14:0], sr_q, 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign load = (state_q == ST_LOAD);
  assign done = (state_q == ST_DONE);
  assign bcd  = acc_q;

endmodule

// File: rtl/seg_display_classic.sv
// Classic score display: clamp, convert to BCD, blank, scan 4 digits.
// Ports: seg_value/disp_en/gameover_classic in; an, seg, busy out.
// Optional blink on game over: define SEG_BLINK_EN.
module seg_display_classic
  import seg_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int REFRESH_HZ   = 1000,
  parameter int BLINK_FRAMES = 250
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seg_value,
  input  logic        disp_en,
  input  logic        gameover_classic,
  output logic [3:0]  an,
  output logic [7:0]  seg,
  output logic        busy
);

  localparam int DIV_RAW = CLK_HZ / (4 * REFRESH_HZ);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = $clog2(DIV + 1);

  logic [15:0]   clamped;
  logic          conv_start;
  logic          conv_busy;
  logic          conv_load;
  logic          conv_done;
  logic [15:0]   conv_bcd;

  logic [15:0]   last_conv_q, last_conv_d;
  logic [15:0]   digits_q, digits_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;
  logic [3:0]    lit;
  logic [3:0]    nib;
  logic          show;

  assign clamped    = (seg_value > SEG_MAX_VALUE) ? SEG_MAX_VALUE
                                                  : seg_value;
  assign conv_start = !conv_busy && (clamped != last_conv_q);

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .din   (clamped),
    .busy  (conv_busy),
    .load  (conv_load),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

`ifdef SEG_BLINK_EN
  localparam int BLINK_CYC = BLINK_FRAMES * 4 * DIV;
  localparam int BW        = $clog2(BLINK_CYC + 1);

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_off_q, blink_off_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_off_d = blink_off_q;
    if (!gameover_classic) begin
      blink_cnt_d = '0;
      blink_off_d = 1'b0;
    end else if (blink_cnt_q == BW'(BLINK_CYC - 1)) begin
      blink_cnt_d = '0;
      blink_off_d = !blink_off_q;
    end else begin
      blink_cnt_d = blink_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_off_q <= blink_off_d;
    end
  end

  assign show = disp_en && !blink_off_d;
`else
  logic unused_gameover;
  assign unused_gameover = gameover_classic;
  assign show = disp_en;
`endif

  // Outputs are built from next-state index and digits so the pins
  // move in the same cycle as the scan index.
  always_comb begin
    last_conv_d = conv_load ? clamped : last_conv_q;
    digits_d    = conv_done ? conv_bcd : digits_q;

    div_d = div_q + 1'b1;
    idx_d = idx_q;
    if (div_q == DW'(DIV - 1)) begin
      div_d = '0;
      idx_d = idx_q + 2'd1;
    end

    lit[0] = 1'b1;
    lit[1] = |digits_d[15:4];
    lit[2] = |digits_d[15:8];
    lit[3] = |digits_d[15:12];

    nib  = digits_d[{idx_d, 2'b00} +: 4];
    an_d = 4'hF;
    seg_d = 8'hFF;
    if (show && lit[idx_d]) begin
      an_d[idx_d] = 1'b0;
      seg_d = {1'b1, glyph(nib)};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_conv_q <= '0;
      digits_q    <= '0;
      div_q       <= '0;
      idx_q       <= '0;
      an_q        <= 4'hF;
      seg_q       <= 8'hFF;
    end else begin
      last_conv_q <= last_conv_d;
      digits_q    <= digits_d;
      div_q       <= div_d;
      idx_q       <= idx_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign busy = conv_busy;

endmodule

// File: tb/tb_seg_display_classic.sv
// Directed self-checking bench for seg_display_classic.
// 400 Hz clock / 10 Hz refresh -> 10-cycle digit period.
module tb_seg_display_classic;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] seg_value = '0;
  logic        disp_en = 1'b1;
  logic        gameover_classic = 1'b0;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] g_seen [4];
  int         lo_cnt [4];
  int         bad;

  seg_display_classic #(
    .CLK_HZ       (400),
    .REFRESH_HZ   (10),
    .BLINK_FRAMES (2)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .seg_value        (seg_value),
    .disp_en          (disp_en),
    .gameover_classic (gameover_classic),
    .an               (an),
    .seg              (seg),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gl(input int d);
    case (d)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observe one full frame (40 cycles) at the pins
  task automatic grab();
    for (int i = 0; i < 4; i++) begin
      g_seen[i] = 8'hFF;
      lo_cnt[i] = 0;
    end
    bad = 0;
    repeat (40) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        if (an[i] == 1'b0) begin
          lo_cnt[i]++;
          g_seen[i] = seg;
        end
      end
      if (an != 4'hF && $countones(~an) != 1) bad++;
      if (an == 4'hF && seg != 8'hFF) bad++;
    end
  endtask

  task automatic check_frame(input string tag, input int val);
    int v;
    int pw;
    int d;
    logic lit;
    grab();
    v = val;
    pw = 1;
    for (int i = 0; i < 4; i++) begin
      d = v % 10;
      v = v / 10;
      lit = (i == 0) || (val >= pw);
      chk($sformatf("%s_glyph%0d", tag, i), 32'(g_seen[i]),
          lit ? 32'(gl(d)) : 32'hFF);
      chk($sformatf("%s_low%0d", tag, i), lo_cnt[i],
          lit ? 10 : 0);
      pw = pw * 10;
    end
    chk({tag, "_glitch"}, bad, 0);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    tick();
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_idle_timeout"}, 32'(busy), 0);
  endtask

  // Return on the first cycle of a slot showing pattern p
  task automatic wait_an(input logic [3:0] p, input string tag);
    int n;
    n = 0;
    while (an == p && n < 100) begin
      tick();
      n++;
    end
    while (an != p && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_slot_timeout"}, 32'(an), 32'(p));
  endtask

  initial begin
    int first_busy;
    int busy_ticks;
    int gap;
    int falls;
    int an1_bad;
    int ok_off;
    int n;
    int run;
    logic pb;
    logic [7:0] first_sd;

    #1 rst = 1'b1;
    repeat (3) tick();
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'hFF);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    tick();
    check_frame("zero", 0);

    seg_value = 16'd37;
    first_busy = -1;
    busy_ticks = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (busy) begin
        busy_ticks++;
        if (first_busy < 0) first_busy = i;
      end
    end
    chk("v37_busy_start", first_busy, 1);
    chk("v37_busy_len", busy_ticks, 18);
    check_frame("v37", 37);

    seg_value = 16'd12345;
    wait_idle("sat");
    check_frame("sat", 9999);

    wait_an(4'b1011, "mid");
    seg_value = 16'd5;
    repeat (4) tick();
    seg_value = 16'd42;
    pb = 1'b1;
    busy_ticks = 0;
    gap = 0;
    falls = 0;
    an1_bad = 0;
    first_sd = 8'h00;
    repeat (60) begin
      tick();
      if (busy) busy_ticks++;
      if (pb && !busy) falls++;
      if (!busy && falls == 1) gap++;
      if (an == 4'b1110 && first_sd == 8'h00) first_sd = seg;
      if (falls == 1 && an[1] == 1'b0) an1_bad++;
      pb = busy;
    end
    chk("mid_first_glyph", 32'(first_sd), 32'(gl(5)));
    chk("mid_busy_ticks", busy_ticks, 32);
    chk("mid_idle_gap", gap, 1);
    chk("mid_conversions", falls, 2);
    chk("mid_d1_blank", an1_bad, 0);
    check_frame("d42", 42);

    wait_an(4'b1110, "en");
    disp_en = 1'b0;
    ok_off = 0;
    repeat (15) begin
      tick();
      if (an == 4'hF && seg == 8'hFF) ok_off++;
    end
    disp_en = 1'b1;
    chk("dis_dark", ok_off, 15);
    tick();
    chk("dis_resume_an", 32'(an), 32'(4'b1101));
    chk("dis_resume_seg", 32'(seg), 32'(gl(4)));

    seg_value = 16'd1234;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    chk("mrst_an", 32'(an), 32'hF);
    chk("mrst_seg", 32'(seg), 32'hFF);
    chk("mrst_busy", 32'(busy), 0);
    tick();
    tick();
    rst = 1'b0;
    wait_idle("mrst");
    check_frame("mrst", 1234);

    seg_value = 16'd9999;
    wait_idle("go");
    gameover_classic = 1'b1;
`ifdef SEG_BLINK_EN
    n = 0;
    while (an != 4'hF && n < 200) begin
      tick();
      n++;
    end
    run = 0;
    while (an == 4'hF && run < 300) begin
      run++;
      tick();
    end
    chk("blink_dark_run", run, 80);
    run = 0;
    while (an != 4'hF && run < 300) begin
      run++;
      tick();
    end
    chk("blink_lit_run", run, 80);
`else
    n = 0;
    repeat (200) begin
      tick();
      if (an == 4'hF) n++;
    end
    chk("steady_no_dark", n, 0);
`endif
    gameover_classic = 1'b0;
    tick();
    tick();
    check_frame("go_off", 9999);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
